ps2_rx_fifo: RTL and testbench

PS/2 keyboard receiver with a scan-code FIFO, sitting between the board PS/2 pins and the memory-mapped I/O bus. It deframes 11-bit PS/2 device-to-host frames from the asynchronous PS2_clk/PS2_Data lines and pushes valid bytes into a small FIFO. It exposes the FIFO head, a non-empty flag and a history word to the bus. The bus pops one byte per read strobe. Scan codes are not translated; software converts them to ASCII.

---
 rtl/ps2_rx_fifo.sv | 238 +++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver feeding a small scan-code FIFO for the I/O bus.
// Optional odd-parity enforcement: define PS2_PARITY_CHECK_EN.
module ps2_rx_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int TIMEOUT    = 5000,
  parameter int FILT       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PS2_clk,
  input  logic        PS2_Data,
  input  logic        ps2_rd,
  output logic        ps2_ready,
  output logic [7:0]  key,
  output logic [31:0] key_d,
  output logic        overflow,
  output logic        frame_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int FW    = $clog2(FILT + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Input conditioning
  logic [1:0]    clk_sync_reg;
  logic [1:0]    data_sync_reg;
  logic          clk_s;
  logic          data_s;
  logic          filt_lvl_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          fall_reg;

  assign clk_s  = clk_sync_reg[1];
  assign data_s = data_sync_reg[1];

  // Idle PS/2 lines are high, so the synchronizers reset to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], PS2_clk};
      data_sync_reg <= {data_sync_reg[0], PS2_Data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_lvl_reg <= 1'b1;
      filt_cnt_reg <= '0;
      fall_reg     <= 1'b0;
    end else begin
      fall_reg <= 1'b0;
      if (clk_s == filt_lvl_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FW'(FILT - 1)) begin
        filt_lvl_reg <= clk_s;
        filt_cnt_reg <= '0;
        fall_reg     <= ~clk_s;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + FW'(1);
      end
    end
  end

  // Frame deframer
  state_t        state_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic [TW-1:0] to_cnt_reg;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_reg;
`endif

  logic par_ok;
  logic timeout_hit;
  logic push_en;
  logic err_evt;

  always_comb begin
    par_ok = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
    par_ok = ^{shift_reg, par_reg};
`endif
    timeout_hit = (state_reg != ST_IDLE) && !fall_reg && (to_cnt_reg == TW'(TIMEOUT));
    push_en     = fall_reg && (state_reg == ST_STOP) && data_s && par_ok;
    err_evt     = timeout_hit ||
                  (fall_reg && (((state_reg == ST_IDLE) && data_s) ||
                                ((state_reg == ST_STOP) && !(data_s && par_ok))));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 8'h00;
      to_cnt_reg  <= '0;
`ifdef PS2_PARITY_CHECK_EN
      par_reg     <= 1'b0;
`endif
    end else begin
      // Saturating inactivity counter; only meaningful inside a frame.
      if (fall_reg || (state_reg == ST_IDLE)) begin
        to_cnt_reg <= '0;
      end else if (to_cnt_reg != TW'(TIMEOUT)) begin
        to_cnt_reg <= to_cnt_reg + TW'(1);
      end

      if (timeout_hit) begin
        state_reg <= ST_IDLE;
      end else if (fall_reg) begin
        case (state_reg)
          ST_IDLE: begin
            if (!data_s) begin
              state_reg   <= ST_DATA;
              bit_cnt_reg <= 3'd0;
            end
          end
          ST_DATA: begin
            shift_reg   <= {data_s, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= ST_PARITY;
            end
          end
          ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_reg <= data_s;
`endif
            state_reg <= ST_STOP;
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  // Scan-code FIFO
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] rd_ptr_next;
  logic          rd_sync_reg;
  logic          rd_prev_reg;
  logic          ready_reg;
  logic [7:0]    key_reg;
  logic [7:0]    key_next;
  logic [31:0]   key_d_reg;
  logic          overflow_reg;
  logic          frame_err_reg;

  logic          empty;
  logic          full;
  logic          pop_req;
  logic          pop;
  logic          push_ok;
  logic          ovf_set;
  logic [AW-1:0] head_idx;

  always_comb begin
    empty       = (wr_ptr_reg == rd_ptr_reg);
    full        = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    pop_req     = rd_sync_reg && !rd_prev_reg;
    pop         = pop_req && !empty;
    push_ok     = push_en && (!full || pop);
    ovf_set     = push_en && full && !pop;
    wr_ptr_next = push_ok ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
    rd_ptr_next = pop ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
    head_idx    = rd_ptr_next[AW-1:0];
    // A byte written this cycle is not yet in mem, so forward it when it becomes the head.
    if (wr_ptr_next == rd_ptr_next) begin
      key_next = 8'h00;
    end else if (push_ok && (wr_ptr_reg[AW-1:0] == head_idx)) begin
      key_next = shift_reg;
    end else begin
      key_next = mem[head_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= shift_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      rd_sync_reg   <= 1'b0;
      rd_prev_reg   <= 1'b0;
      ready_reg     <= 1'b0;
      key_reg       <= 8'h00;
      key_d_reg     <= 32'h0;
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      rd_sync_reg <= ps2_rd;
      rd_prev_reg <= rd_sync_reg;
      ready_reg   <= (wr_ptr_next != rd_ptr_next);
      key_reg     <= key_next;
      if (push_ok) begin
        key_d_reg <= {key_d_reg[23:0], shift_reg};
      end
      // Status bits clear when read by a pop, but a new event in that cycle wins.
      if (ovf_set) begin
        overflow_reg <= 1'b1;
      end else if (pop) begin
        overflow_reg <= 1'b0;
      end
      if (err_evt) begin
        frame_err_reg <= 1'b1;
      end else if (pop) begin
        frame_err_reg <= 1'b0;
      end
    end
  end

  assign ps2_ready = ready_reg;
  assign key       = key_reg;
  assign key_d     = key_d_reg;
  assign overflow  = overflow_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: PS/2 frames are bit-banged on the raw pins
// and FIFO/status outputs are compared with hand-computed values.
module tb_ps2_rx_fifo;

  localparam int TIMEOUT = 5000;
  localparam int HP      = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PS2_clk = 1'b1;
  logic        PS2_Data = 1'b1;
  logic        ps2_rd = 1'b0;
  logic        ps2_ready;
  logic [7:0]  key;
  logic [31:0] key_d;
  logic        overflow;
  logic        frame_err;

  int tests_run    = 0;
  int tests_failed = 0;

  ps2_rx_fifo #(
    .DEPTH_LOG2(3),
    .TIMEOUT   (TIMEOUT),
    .FILT      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .PS2_clk  (PS2_clk),
    .PS2_Data (PS2_Data),
    .ps2_rd   (ps2_rd),
    .ps2_ready(ps2_ready),
    .key      (key),
    .key_d    (key_d),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  // Sends the first n bits of vec (bit 0 = start) as PS/2 clock cycles.
  task automatic send_bits(input logic [10:0] vec, input int n);
    for (int i = 0; i < n; i++) begin
      PS2_Data = vec[i];
      wait_cycles(HP);
      PS2_clk = 1'b0;
      wait_cycles(HP);
      PS2_clk = 1'b1;
    end
    wait_cycles(HP);
    PS2_Data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par);
    send_bits({1'b1, par, b, 1'b0}, 11);
    $display("[TB] frame %h parity %0d sent", b, par);
  endtask

  task automatic pop_once();
    ps2_rd = 1'b1;
    wait_cycles(1);
    ps2_rd = 1'b0;
    wait_cycles(3);
    $display("[TB] pop strobe");
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(2);
    $display("[TB] reset");
  endtask

  initial begin
    wait_cycles(3);
    check("reset_ready", {31'd0, ps2_ready}, 32'd0);
    check("reset_key", {24'd0, key}, 32'd0);
    check("reset_key_d", key_d, 32'd0);
    check("reset_ovf", {31'd0, overflow}, 32'd0);
    check("reset_ferr", {31'd0, frame_err}, 32'd0);
    rst = 1'b1;
    wait_cycles(2);

    // Single frame and single pop
    send_frame(8'h1C, 1'b0);
    check("t1_ready", {31'd0, ps2_ready}, 32'd1);
    check("t1_key", {24'd0, key}, 32'h1C);
    check("t1_key_d", key_d, 32'h0000001C);
    check("t1_ferr", {31'd0, frame_err}, 32'd0);
    pop_once();
    check("t1_pop_ready", {31'd0, ps2_ready}, 32'd0);
    check("t1_pop_key", {24'd0, key}, 32'h00);

    // Held read strobe pops once
    do_reset();
    send_frame(8'hF0, 1'b1);
    send_frame(8'h1C, 1'b0);
    check("t2_key_head", {24'd0, key}, 32'hF0);
    check("t2_key_d", key_d, 32'h0000F01C);
    ps2_rd = 1'b1;
    wait_cycles(10);
    check("t2_hold_key", {24'd0, key}, 32'h1C);
    check("t2_hold_ready", {31'd0, ps2_ready}, 32'd1);
    ps2_rd = 1'b0;
    wait_cycles(2);
    pop_once();
    check("t2_empty", {31'd0, ps2_ready}, 32'd0);

    // Fill, overflow, drain in order
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      send_frame(8'(i), odd_par(8'(i)));
    end
    check("t3_full_ovf", {31'd0, overflow}, 32'd0);
    send_frame(8'h09, odd_par(8'h09));
    check("t3_ovf", {31'd0, overflow}, 32'd1);
    check("t3_key_d", key_d, 32'h05060708);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("t3_key%0d", i), {24'd0, key}, 32'(i));
      pop_once();
      if (i == 1) check("t3_ovf_clr", {31'd0, overflow}, 32'd0);
    end
    check("t3_drained", {31'd0, ps2_ready}, 32'd0);
    check("t3_drained_key", {24'd0, key}, 32'h00);

    // Wrong parity bit
    do_reset();
    send_frame(8'h1C, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check("t4_ready", {31'd0, ps2_ready}, 32'd0);
    check("t4_ferr", {31'd0, frame_err}, 32'd1);
`else
    check("t4_ready", {31'd0, ps2_ready}, 32'd1);
    check("t4_key", {24'd0, key}, 32'h1C);
    check("t4_ferr", {31'd0, frame_err}, 32'd0);
`endif

    // Partial frame abandoned by timeout
    do_reset();
    send_bits(11'b111_0000_1010, 5);
    check("t5_no_err_yet", {31'd0, frame_err}, 32'd0);
    wait_cycles(TIMEOUT + 10);
    check("t5_timeout_err", {31'd0, frame_err}, 32'd1);
    send_frame(8'h2A, 1'b0);
    check("t5_ferr", {31'd0, frame_err}, 32'd1);
    check("t5_key", {24'd0, key}, 32'h2A);
    check("t5_key_d", key_d, 32'h0000002A);
    pop_once();
    check("t5_only_one", {31'd0, ps2_ready}, 32'd0);
    check("t5_ferr_clr", {31'd0, frame_err}, 32'd0);

    // Bad stop bit
    send_bits({1'b0, odd_par(8'h44), 8'h44, 1'b0}, 11);
    check("t6_stop_err", {31'd0, frame_err}, 32'd1);
    check("t6_stop_nopush", {31'd0, ps2_ready}, 32'd0);

    // Reset mid-frame with bytes queued
    do_reset();
    send_frame(8'h11, odd_par(8'h11));
    send_frame(8'h22, odd_par(8'h22));
    check("t7_queued", {31'd0, ps2_ready}, 32'd1);
    send_bits(11'b111_0101_0100, 4);
    rst = 1'b0;
    #1;
    check("t7_rst_ready", {31'd0, ps2_ready}, 32'd0);
    check("t7_rst_key", {24'd0, key}, 32'd0);
    check("t7_rst_key_d", key_d, 32'd0);
    check("t7_rst_ovf", {31'd0, overflow}, 32'd0);
    check("t7_rst_ferr", {31'd0, frame_err}, 32'd0);
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(2);
    send_frame(8'h33, odd_par(8'h33));
    check("t7_key", {24'd0, key}, 32'h33);
    check("t7_ready", {31'd0, ps2_ready}, 32'd1);
    check("t7_key_d", key_d, 32'h00000033);
    check("t7_ferr", {31'd0, frame_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
